cic_decim_mc: RTL and testbench

Runtime-programmable, multi-channel CIC decimator for the next-generation DDC datapath. It replaces the single-channel, fixed-configuration CIC with a parametrised core that varies channel count, sample width, stage count and maximum decimation, and it adds in-band end-of-burst flushing of partial decimation blocks. It sits between the DDC frequency-shift stage and the halfband chain. Gain compensation and rounding are done downstream by the existing scale stage.

---
 rtl/cic_decim_mc_pkg.sv | 19 +
 rtl/cic_decim_mc_lane.sv | 75 +++++++
 rtl/cic_decim_mc.sv | 104 ++++++++++
 tb/tb_cic_decim_mc.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_decim_mc_pkg.sv
// Shared types and width helpers for the multi-channel CIC decimator.
package cic_decim_mc_pkg;

  // Per-decimation-event control broadcast from the controller to every lane.
  typedef struct packed {
    logic dec;
    logic flush;
    logic clear;
  } cic_ctrl_t;

  function automatic int rate_w(input int max_decim);
    return $clog2(max_decim + 1);
  endfunction

  function automatic int acc_w(input int width, input int num_stages, input int max_decim);
    return width + num_stages * $clog2(max_decim);
  endfunction

endpackage

// File: rtl/cic_decim_mc_lane.sv
// One channel's I and Q integrator/comb cascades with its output data register.
// Latency: comb result is registered on the cycle after a decimation event.
// Backpressure: none locally; the shared controller only asserts dec when the output register is free.
module cic_decim_mc_lane
  import cic_decim_mc_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int NUM_STAGES = 4,
  parameter int ACC_W      = 48
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               acc,
  input  cic_ctrl_t          ctrl,
  input  logic [2*WIDTH-1:0] in_dat,
  output logic [2*ACC_W-1:0] out_dat
);

  for (genvar c = 0; c < 2; c++) begin : g_comp
    logic [ACC_W-1:0] integ     [NUM_STAGES];
    logic [ACC_W-1:0] integ_nxt [NUM_STAGES];
    logic [ACC_W-1:0] comb_dly  [NUM_STAGES];
    logic [ACC_W-1:0] comb_in   [NUM_STAGES];
    logic [ACC_W-1:0] comb_out;
    logic [ACC_W-1:0] out_q;
    logic [WIDTH-1:0] x;

    assign x = in_dat[c*WIDTH +: WIDTH];

    // Unpipelined cascade: every stage sees this beat's updated value from the stage before.
    always_comb begin
      logic [ACC_W-1:0] run;
      run = {{(ACC_W-WIDTH){x[WIDTH-1]}}, x};
      for (int k = 0; k < NUM_STAGES; k++) begin
        run          = integ[k] + run;
        integ_nxt[k] = run;
      end
    end

    always_comb begin
      logic [ACC_W-1:0] diff;
      diff = integ[NUM_STAGES-1];
      for (int k = 0; k < NUM_STAGES; k++) begin
        comb_in[k] = diff;
        diff       = diff - comb_dly[k];
      end
      comb_out = diff;
    end

    // A flush clears the filter right after its final comb load so the next burst starts clean.
    always_ff @(posedge clk) begin
      if (reset || ctrl.clear || (ctrl.dec && ctrl.flush)) begin
        for (int k = 0; k < NUM_STAGES; k++) begin
          integ[k]    <= '0;
          comb_dly[k] <= '0;
        end
      end else begin
        if (acc) begin
          for (int k = 0; k < NUM_STAGES; k++) integ[k] <= integ_nxt[k];
        end
        if (ctrl.dec) begin
          for (int k = 0; k < NUM_STAGES; k++) comb_dly[k] <= comb_in[k];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) out_q <= '0;
      else if (ctrl.dec) out_q <= comb_out;
    end

    assign out_dat[c*ACC_W +: ACC_W] = out_q;
  end

endmodule

// File: rtl/cic_decim_mc.sv
// Runtime-programmable multi-channel CIC decimator with in-band end-of-burst flush.
// Latency: o_tvalid rises two edges after the edge opening the decimating beat's accept cycle.
// Backpressure: i_tready drops during rate_stb, a pending decimation, or a held output beat.
module cic_decim_mc
  import cic_decim_mc_pkg::*;
#(
  parameter  int WIDTH      = 16,
  parameter  int NUM_CHAN   = 1,
  parameter  int NUM_STAGES = 4,
  parameter  int MAX_DECIM  = 255,
  localparam int RATE_W     = rate_w(MAX_DECIM),
  localparam int ACC_W      = acc_w(WIDTH, NUM_STAGES, MAX_DECIM)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [RATE_W-1:0]            rate,
  input  logic                         rate_stb,
  input  logic [NUM_CHAN*2*WIDTH-1:0]  i_tdata,
  input  logic                         i_tlast,
  input  logic                         i_tvalid,
  output logic                         i_tready,
  output logic [NUM_CHAN*2*ACC_W-1:0]  o_tdata,
  output logic                         o_tlast,
  output logic                         o_partial,
  output logic                         o_tvalid,
  input  logic                         o_tready
);

  logic [RATE_W-1:0] rate_q;
  logic [RATE_W-1:0] cnt;
  logic [RATE_W-1:0] last_cnt;
  logic              dec_pend;
  logic              pend_last;
  logic              pend_partial;
  logic              accept;
  logic              at_end;
  logic              dec_evt;
  logic              ld;
  cic_ctrl_t         ctrl;

  // A programmed rate of 0 behaves as 1, so the terminal count is 0 either way.
  assign last_cnt = (rate_q == '0) ? '0 : rate_q - RATE_W'(1);
  assign i_tready = ~rate_stb & ~dec_pend & (~o_tvalid | o_tready);
  assign accept   = i_tvalid & i_tready;
  assign at_end   = (cnt == last_cnt);
  assign dec_evt  = accept & (at_end | i_tlast);
  assign ld       = dec_pend & ~rate_stb;
  assign ctrl     = '{dec: ld, flush: pend_last, clear: rate_stb};

  always_ff @(posedge clk) begin
    if (reset) begin
      rate_q       <= '0;
      cnt          <= '0;
      dec_pend     <= 1'b0;
      pend_last    <= 1'b0;
      pend_partial <= 1'b0;
    end else if (rate_stb) begin
      rate_q   <= rate;
      cnt      <= '0;
      dec_pend <= 1'b0;
    end else if (dec_evt) begin
      cnt          <= '0;
      dec_pend     <= 1'b1;
      pend_last    <= i_tlast;
      pend_partial <= i_tlast & ~at_end;
    end else begin
      dec_pend <= 1'b0;
      if (accept) cnt <= cnt + RATE_W'(1);
    end
  end

  // The output register is always empty when ld fires: accepting the decimating beat required it.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_tvalid  <= 1'b0;
      o_tlast   <= 1'b0;
      o_partial <= 1'b0;
    end else if (ld) begin
      o_tvalid  <= 1'b1;
      o_tlast   <= pend_last;
      o_partial <= pend_partial;
    end else if (o_tready) begin
      o_tvalid  <= 1'b0;
      o_tlast   <= 1'b0;
      o_partial <= 1'b0;
    end
  end

  for (genvar ch = 0; ch < NUM_CHAN; ch++) begin : g_lane
    cic_decim_mc_lane #(
      .WIDTH      (WIDTH),
      .NUM_STAGES (NUM_STAGES),
      .ACC_W      (ACC_W)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .acc     (accept),
      .ctrl    (ctrl),
      .in_dat  (i_tdata[ch*2*WIDTH +: 2*WIDTH]),
      .out_dat (o_tdata[ch*2*ACC_W +: 2*ACC_W])
    );
  end

endmodule

// File: tb/tb_cic_decim_mc.sv
// Scoreboard bench for cic_decim_mc: a closed-form binomial CIC model predicts every output.
module tb_cic_decim_mc;
  localparam int WIDTH = 16, NUM_CHAN = 2, NUM_STAGES = 4, MAX_DECIM = 255;
  localparam int RATE_W = 8, ACC_W = 48, NCOMP = NUM_CHAN * 2;

  logic clk = 1'b0;
  logic reset, rate_stb, i_tlast, i_tvalid, i_tready, o_tlast, o_partial, o_tvalid, o_tready;
  logic [RATE_W-1:0] rate;
  logic [NCOMP*WIDTH-1:0] i_tdata;
  logic [NCOMP*ACC_W-1:0] o_tdata;

  always #5 clk = ~clk;

  cic_decim_mc #(.WIDTH(WIDTH), .NUM_CHAN(NUM_CHAN), .NUM_STAGES(NUM_STAGES), .MAX_DECIM(MAX_DECIM)) dut (
    .clk(clk), .reset(reset), .rate(rate), .rate_stb(rate_stb), .i_tdata(i_tdata), .i_tlast(i_tlast),
    .i_tvalid(i_tvalid), .i_tready(i_tready), .o_tdata(o_tdata), .o_tlast(o_tlast), .o_partial(o_partial),
    .o_tvalid(o_tvalid), .o_tready(o_tready));

  typedef struct {
    logic [NCOMP*ACC_W-1:0] dat;
    logic                   last;
    logic                   partial;
  } exp_t;
  typedef logic [NCOMP-1:0][63:0] snap_t;

  exp_t expq[$];
  logic [NCOMP*WIDTH-1:0] beats[$];
  snap_t snaps[$];
  int mrate = 1, mcnt = 0;
  int checks = 0, errors = 0;
  int stall_mode = 0;
  int n_out = 0;
  logic [NCOMP*ACC_W-1:0] last_out;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic longint binom(input longint n, input int k);
    longint r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  // Burst output m = N-th backward difference of the N-fold running sum sampled at decimation points.
  task automatic model_beat(input logic [NCOMP*WIDTH-1:0] d, input logic last);
    exp_t e;
    snap_t s, p;
    logic [NCOMP*WIDTH-1:0] bw;
    logic [WIDTH-1:0] xv;
    longint acc, xs, y;
    int n, m;
    beats.push_back(d);
    mcnt++;
    if (mcnt == mrate || last) begin
      n = beats.size();
      for (int c = 0; c < NCOMP; c++) begin
        acc = 0;
        for (int j = 0; j < n; j++) begin
          bw = beats[j];
          xv = bw[c*WIDTH +: WIDTH];
          xs = $signed(xv);
          acc += xs * binom(n - 1 - j + NUM_STAGES - 1, NUM_STAGES - 1);
        end
        s[c] = acc;
      end
      snaps.push_back(s);
      m = snaps.size() - 1;
      for (int c = 0; c < NCOMP; c++) begin
        y = 0;
        for (int k = 0; k <= NUM_STAGES; k++) begin
          if (m - k >= 0) begin
            p = snaps[m-k];
            y += ((k % 2) ? -1 : 1) * binom(NUM_STAGES, k) * longint'(p[c]);
          end
        end
        e.dat[c*ACC_W +: ACC_W] = y[ACC_W-1:0];
      end
      e.last = last;
      e.partial = last && (mcnt != mrate);
      expq.push_back(e);
      mcnt = 0;
      if (last) begin
        beats.delete();
        snaps.delete();
      end
    end
  endtask

  task automatic model_clear(input int r);
    beats.delete();
    snaps.delete();
    mcnt = 0;
    mrate = (r == 0) ? 1 : r;
  endtask

  task automatic set_rate(input int r);
    assert (r <= MAX_DECIM) else $error("rate %0d above MAX_DECIM", r);
    rate = RATE_W'(r);
    rate_stb = 1'b1;
    @(negedge clk);
    chk("rdy_during_stb", 256'(i_tready), 256'(0));
    @(posedge clk); #1;
    rate_stb = 1'b0;
    model_clear(r);
  endtask

  task automatic send(input logic [NCOMP*WIDTH-1:0] d, input logic last);
    logic accepted = 1'b0;
    i_tvalid = 1'b1;
    i_tdata = d;
    i_tlast = last;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (i_tready) begin
        accepted = 1'b1;
        break;
      end
    end
    if (accepted) begin
      @(posedge clk); #1;
      model_beat(d, last);
    end else begin
      checks++; errors++;
      $display("FAIL send_timeout: i_tready stayed 0, required 1 within 300 cycles");
    end
    i_tvalid = 1'b0;
    i_tlast = 1'b0;
    if (!accepted) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (!(expq.size() == 0 && !o_tvalid) && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 5000) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d outputs still expected, required 0", expq.size());
    end
  endtask

  function automatic logic [NCOMP*WIDTH-1:0] all_comp(input logic [WIDTH-1:0] v);
    logic [NCOMP*WIDTH-1:0] d;
    for (int c = 0; c < NCOMP; c++) d[c*WIDTH +: WIDTH] = v;
    return d;
  endfunction

  function automatic logic [NCOMP*WIDTH-1:0] rnd_beat();
    logic [NCOMP*WIDTH-1:0] d;
    d = {$urandom(), $urandom()};
    return d;
  endfunction

  // Output side: o_tready pattern plus scoreboard pop and hold-stability checks.
  initial begin
    o_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      o_tready = (stall_mode == 0) ? 1'b1 : (stall_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
    end
  end

  initial begin
    logic held;
    logic [255:0] hsnap;
    exp_t e;
    held = 1'b0;
    hsnap = '0;
    forever begin
      @(negedge clk);
      if (reset) held = 1'b0;
      else begin
        if (held) chk("hold_stable", 256'({o_tvalid, o_tlast, o_partial, o_tdata}), hsnap);
        held = o_tvalid & ~o_tready;
        hsnap = 256'({o_tvalid, o_tlast, o_partial, o_tdata});
        if (o_tvalid && o_tready) begin
          if (expq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_out: got %h, required no output", o_tdata);
          end else begin
            e = expq.pop_front();
            chk("out_dat", 256'(o_tdata), 256'(e.dat));
            chk("out_last_partial", 256'({o_tlast, o_partial}), 256'({e.last, e.partial}));
            last_out = o_tdata;
            n_out++;
          end
        end
      end
    end
  end

  initial begin
    logic [NCOMP*WIDTH-1:0] d;
    logic [NCOMP*ACC_W-1:0] want;
    longint big;
    int lat, n0;
    reset = 1'b1; rate_stb = 1'b0; rate = '0;
    i_tvalid = 1'b0; i_tlast = 1'b0; i_tdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out", 256'({o_tvalid, o_tlast, o_partial, o_tdata}), 256'(0));
    chk("rst_rdy", 256'(i_tready), 256'(1));
    @(posedge clk); #1;

    // R=1 ramp: outputs mirror inputs, only the final beat flagged last.
    set_rate(1);
    for (int n = 0; n < 512; n++) begin
      d[0*WIDTH +: WIDTH] = WIDTH'(n);
      d[1*WIDTH +: WIDTH] = WIDTH'(n);
      d[2*WIDTH +: WIDTH] = WIDTH'(-n);
      d[3*WIDTH +: WIDTH] = WIDTH'(n);
      send(d, n == 511);
      if (n == 0) begin
        lat = 0;
        while (!o_tvalid && lat < 10) begin
          @(posedge clk); #1;
          lat++;
        end
        chk("latency_edges", 256'(lat + 1), 256'(2));
      end
    end
    wait_drain();

    // Rate 0 behaves as R=1.
    set_rate(0);
    for (int n = 0; n < 5; n++) send(rnd_beat(), n == 4);
    wait_drain();

    // R=4 constant input: steady gain R^N.
    set_rate(4);
    for (int n = 0; n < 64; n++) send(all_comp(16'd100), n == 63);
    wait_drain();
    for (int c = 0; c < NCOMP; c++) want[c*ACC_W +: ACC_W] = 48'd25600;
    chk("r4_steady", 256'(last_out), 256'(want));

    // R=3 partial flush, then a second burst that must start from clean state.
    set_rate(3);
    for (int n = 0; n < 10; n++) send(all_comp(16'd1), n == 9);
    for (int n = 0; n < 12; n++) send(all_comp(16'd1), n == 11);
    wait_drain();

    // R=255 full-scale negative input: exact full-precision result.
    set_rate(255);
    n0 = n_out;
    for (int n = 0; n < 2048; n++) send(all_comp(16'h8000), 1'b0);
    wait_drain();
    big = -32768;
    repeat (4) big = big * 255;
    for (int c = 0; c < NCOMP; c++) want[c*ACC_W +: ACC_W] = big[ACC_W-1:0];
    chk("r255_steady", 256'(last_out), 256'(want));
    chk("r255_count", 256'(n_out - n0), 256'(8));

    // R=2 with random stalls, then a rate change while an output is held.
    set_rate(2);
    stall_mode = 1;
    for (int n = 0; n < 40; n++) send(rnd_beat(), n == 39);
    wait_drain();
    stall_mode = 2;
    @(posedge clk); #1;
    send(rnd_beat(), 1'b0);
    send(rnd_beat(), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("held_before_stb", 256'(o_tvalid), 256'(1));
    @(posedge clk); #1;
    set_rate(5);
    @(negedge clk);
    chk("held_after_stb", 256'(o_tvalid), 256'(1));
    repeat (12) @(posedge clk);
    #1;
    stall_mode = 1;
    for (int n = 0; n < 23; n++) send(rnd_beat(), n == 22);
    wait_drain();
    stall_mode = 0;

    // Reset mid-burst abandons state; rate falls back to 1.
    set_rate(3);
    for (int n = 0; n < 4; n++) send(rnd_beat(), 1'b0);
    wait_drain();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear(0);
    @(negedge clk);
    chk("rst2_out", 256'({o_tvalid, o_tlast, o_partial, o_tdata}), 256'(0));
    @(posedge clk); #1;
    for (int n = 0; n < 3; n++) send(rnd_beat(), n == 2);
    wait_drain();

    chk("queue_empty", 256'(expq.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
